// File: rtl/lutram_fifo_rr_sched_pkg.sv
// Shared definitions for the round-robin FIFO drain scheduler.
package lutram_fifo_rr_sched_pkg;

  // Scheduler FSM encodings, kept as plain constants for older tool flows
  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  // Index width for n items, never less than one bit
  function automatic int log2x(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lutram_fifo_rr_sched_if.sv
// Source-side and consumer-side signals of the FIFO drain scheduler.
interface lutram_fifo_rr_sched_if
  import lutram_fifo_rr_sched_pkg::*;
  #(
    parameter int NSRC   = 4,
    parameter int DWIDTH = 32
  );

  localparam int SW = log2x(NSRC);

  logic [NSRC-1:0]   src_empty;
  logic [NSRC-1:0]   src_re;
  logic [DWIDTH-1:0] src_dout [0:NSRC-1];
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_data;
  logic [SW-1:0]     out_src;

  modport master (
    input  src_empty, src_dout, out_ready,
    output src_re, out_valid, out_data, out_src
  );

  modport slave (
    output src_empty, src_dout, out_ready,
    input  src_re, out_valid, out_data, out_src
  );

endinterface

// File: rtl/lutram_fifo_rr_sched_obuf.sv
// Two-entry output queue holding a data word and its source index.
module lutram_fifo_rr_sched_obuf #(
  parameter int DWIDTH = 32,
  parameter int SW     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wrEn,
  input  logic [DWIDTH-1:0] i_wrData,
  input  logic [SW-1:0]     i_wrSrc,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DWIDTH-1:0] o_data,
  output logic [SW-1:0]     o_src,
  output logic [1:0]        o_count
);

  logic [DWIDTH-1:0] r_data [0:1];
  logic [SW-1:0]     r_src  [0:1];
  logic [1:0]        r_count;
  logic              w_rdEn;

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_data[0];
  assign o_src   = r_src[0];
  assign o_count = r_count;
  assign w_rdEn  = o_valid && i_ready;

  // Entry 0 is always the head; a read shifts entry 1 down, a write lands behind the last valid entry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= 2'd0;
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_src[0]  <= '0;
      r_src[1]  <= '0;
    end else begin
      case ({i_wrEn, w_rdEn})
        2'b01: begin
          r_data[0] <= r_data[1];
          r_src[0]  <= r_src[1];
          r_count   <= r_count - 2'd1;
        end
        2'b10: begin
          if (r_count == 2'd0) begin
            r_data[0] <= i_wrData;
            r_src[0]  <= i_wrSrc;
          end else begin
            r_data[1] <= i_wrData;
            r_src[1]  <= i_wrSrc;
          end
          r_count <= r_count + 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_data[0] <= i_wrData;
            r_src[0]  <= i_wrSrc;
          end else begin
            r_data[0] <= r_data[1];
            r_src[0]  <= r_src[1];
            r_data[1] <= i_wrData;
            r_src[1]  <= i_wrSrc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // A write into a full queue without a simultaneous read would lose a word
  obufNoOverflow: assert property (@(posedge clk) disable iff (rst)
    !(i_wrEn && !w_rdEn && (r_count == 2'd2)));

endmodule

// File: rtl/lutram_fifo_rr_sched.sv
// Round-robin drain of NSRC synchronous FIFOs into one consumer, with
// per-grant bursts of up to QUANTUM pops and a credit-guarded output queue.
module lutram_fifo_rr_sched
  import lutram_fifo_rr_sched_pkg::*;
  #(
    parameter int NSRC    = 4,
    parameter int DWIDTH  = 32,
    parameter int RDLAT   = 1,
    parameter int QUANTUM = 4
  ) (
    input logic clk,
    input logic rst,
    lutram_fifo_rr_sched_if.master io_sched
  );

  localparam int SW = log2x(NSRC);
  localparam int CW = log2x(QUANTUM);
  localparam logic [CW-1:0] CNT_LAST = CW'(QUANTUM - 1);

  logic [0:0]        r_state;
  logic [SW-1:0]     r_sel;
  logic [SW-1:0]     r_rrPtr;
  logic [CW-1:0]     r_cnt;
  logic              r_inFlight;
  logic [SW-1:0]     r_flightSrc;

  logic              w_found;
  logic [SW-1:0]     w_winner;
  logic              w_outValid;
  logic [1:0]        w_bufCount;
  logic              w_deq;
  logic [2:0]        w_occ;
  logic              w_creditOk;
  logic              w_pop;
  logic              w_capEn;
  logic [SW-1:0]     w_capSrc;
  logic [DWIDTH-1:0] w_capData;

  // First non-empty source after ptr, wrapping; iterating downward leaves the nearest one
  function automatic logic [SW:0] rrPick(input logic [NSRC-1:0] empty, input logic [SW-1:0] ptr);
    logic [SW-1:0] idx;
    rrPick = '0;
    for (int k = NSRC; k >= 1; k--) begin
      idx = ptr + SW'(k);
      if (!empty[idx]) rrPick = {1'b1, idx};
    end
  endfunction

  // Arbitration candidate, only acted on in the ARB state
  always_comb begin
    {w_found, w_winner} = rrPick(io_sched.src_empty, r_rrPtr);
  end

  // Words already committed (queued or still coming back) must leave room for one more
  assign w_deq      = w_outValid && io_sched.out_ready;
  assign w_occ      = {1'b0, w_bufCount} + {2'b00, r_inFlight};
  assign w_creditOk = (w_occ - {2'b00, w_deq}) < 3'd2;
  assign w_pop      = !rst && (r_state == ST_BURST) && !io_sched.src_empty[r_sel] && w_creditOk;

  // One-hot read enable towards the granted source
  always_comb begin
    io_sched.src_re = '0;
    if (w_pop) io_sched.src_re[r_sel] = 1'b1;
  end

  // Grant selection and burst accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ARB;
      r_sel   <= '0;
      r_rrPtr <= SW'(NSRC - 1);
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_ARB: begin
          if (w_found) begin
            r_sel   <= w_winner;
            r_cnt   <= '0;
            r_state <= ST_BURST;
          end
        end
        default: begin
          if (io_sched.src_empty[r_sel]) begin
            r_rrPtr <= r_sel;
            r_state <= ST_ARB;
          end else if (w_pop) begin
            if (r_cnt == CNT_LAST) begin
              r_rrPtr <= r_sel;
              r_state <= ST_ARB;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Remember a pop whose data only appears on the next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inFlight  <= 1'b0;
      r_flightSrc <= '0;
    end else begin
      r_inFlight  <= (RDLAT == 1) && w_pop;
      r_flightSrc <= r_sel;
    end
  end

  // Route the returning word into the output queue at the right time
  always_comb begin
    if (RDLAT == 0) begin
      w_capEn  = w_pop;
      w_capSrc = r_sel;
    end else begin
      w_capEn  = r_inFlight;
      w_capSrc = r_flightSrc;
    end
    w_capData = io_sched.src_dout[w_capSrc];
  end

  lutram_fifo_rr_sched_obuf #(
    .DWIDTH (DWIDTH),
    .SW     (SW)
  ) u_obuf (
    .clk      (clk),
    .rst      (rst),
    .i_wrEn   (w_capEn),
    .i_wrData (w_capData),
    .i_wrSrc  (w_capSrc),
    .i_ready  (io_sched.out_ready),
    .o_valid  (w_outValid),
    .o_data   (io_sched.out_data),
    .o_src    (io_sched.out_src),
    .o_count  (w_bufCount)
  );

  assign io_sched.out_valid = w_outValid;

  srcReOneHot: assert property (@(posedge clk) disable iff (rst) $onehot0(io_sched.src_re));
  srcReNotEmpty: assert property (@(posedge clk) disable iff (rst)
    (io_sched.src_re & io_sched.src_empty) == '0);

endmodule

// File: tb/tb_lutram_fifo_rr_sched.sv
// Directed bench for the round-robin FIFO drain scheduler (NSRC=4, RDLAT=1, QUANTUM=4).
module tb_lutram_fifo_rr_sched;

  localparam int NSRC   = 4;
  localparam int DWIDTH = 32;
  localparam int DEPTH  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  lutram_fifo_rr_sched_if #(.NSRC(NSRC), .DWIDTH(DWIDTH)) bus();

  lutram_fifo_rr_sched #(
    .NSRC    (NSRC),
    .DWIDTH  (DWIDTH),
    .RDLAT   (1),
    .QUANTUM (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .io_sched (bus)
  );

  logic [DWIDTH-1:0] srcMem  [NSRC][DEPTH];
  logic [DWIDTH-1:0] srcDout [NSRC];
  int                wrPtr   [NSRC];
  int                rdPtr   [NSRC];

  logic [DWIDTH-1:0] rxData  [$];
  logic [1:0]        rxSrc   [$];
  int                rxCycle [$];
  int                popTotal    = 0;
  int                cycleCount  = 0;
  int                testsRun    = 0;
  int                testsFailed = 0;

  // Source FIFO models: registered read data one cycle after the pop, flushed by the shared reset
  always @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (rst) begin
        rdPtr[i] <= wrPtr[i];
      end else if (bus.src_re[i] && (rdPtr[i] != wrPtr[i])) begin
        srcDout[i] <= srcMem[i][rdPtr[i] % DEPTH];
        rdPtr[i]   <= rdPtr[i] + 1;
      end
    end
  end

  // Present the FIFO model flags and data on the interface
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      bus.src_empty[i] = (rdPtr[i] == wrPtr[i]);
      bus.src_dout[i]  = srcDout[i];
    end
  end

  // Free-running cycle stamp
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Record accepted words and issued pops mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        rxData.push_back(bus.out_data);
        rxSrc.push_back(bus.out_src);
        rxCycle.push_back(cycleCount);
      end
      for (int i = 0; i < NSRC; i++) begin
        if (bus.src_re[i] && !bus.src_empty[i]) popTotal++;
      end
    end
  end

  // Hard stop in case the directed sequence ever stalls
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout, expected sequence end");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [DWIDTH-1:0] mkWord(input int s, input int t, input int i);
    return DWIDTH'((s << 24) | (t << 16) | i);
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int s, input int t, input int n);
    for (int i = 0; i < n; i++) begin
      srcMem[s][wrPtr[s] % DEPTH] = mkWord(s, t, i);
      wrPtr[s] = wrPtr[s] + 1;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic waitWords(input string tag, input int base, input int n, input int budget);
    int waited;
    waited = 0;
    while ((rxData.size() < base + n) && (waited < budget)) begin
      tick();
      waited++;
    end
    checkOutput(tag, 64'(rxData.size() - base), 64'(n));
  endtask

  task automatic checkWord(input string tag, input int idx, input int s, input logic [DWIDTH-1:0] w);
    if (idx < rxData.size())
      checkOutput(tag, {30'd0, rxSrc[idx], rxData[idx]}, {30'd0, 2'(s), w});
    else
      checkOutput(tag, 64'hDEAD_0000_0000_0000, {30'd0, 2'(s), w});
  endtask

  initial begin
    int base;
    int pop0;
    int k;
    int expGap;

    for (int i = 0; i < NSRC; i++) wrPtr[i] = 0;
    bus.out_ready = 1'b1;

    // Reset state
    doReset();
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_out_data",  64'(bus.out_data),  64'd0);
    checkOutput("rst_out_src",   64'(bus.out_src),   64'd0);
    checkOutput("rst_src_re",    64'(bus.src_re),    64'd0);

    // Single source with three words, no backpressure
    base = rxData.size();
    pop0 = popTotal;
    applyStimulus(0, 1, 3);
    tick();
    checkOutput("t1_re_c1", 64'(bus.src_re), 64'b0001);
    tick();
    checkOutput("t1_re_c2", 64'(bus.src_re), 64'b0001);
    tick();
    checkOutput("t1_re_c3", 64'(bus.src_re), 64'b0001);
    checkOutput("t1_valid_c3", 64'(bus.out_valid), 64'd1);
    checkOutput("t1_data_A", {30'd0, bus.out_src, bus.out_data}, {32'd0, mkWord(0, 1, 0)});
    tick();
    checkOutput("t1_re_c4", 64'(bus.src_re), 64'b0000);
    checkOutput("t1_data_B", {30'd0, bus.out_src, bus.out_data}, {32'd0, mkWord(0, 1, 1)});
    tick();
    checkOutput("t1_data_C", {30'd0, bus.out_src, bus.out_data}, {32'd0, mkWord(0, 1, 2)});
    tick();
    checkOutput("t1_idle_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("t1_idle_re", 64'(bus.src_re), 64'd0);
    checkOutput("t1_pops", 64'(popTotal - pop0), 64'd3);
    checkOutput("t1_rx", 64'(rxData.size() - base), 64'd3);

    // Four sources with ten words each: quantum rotation, then short final bursts
    doReset();
    base = rxData.size();
    for (int s = 0; s < NSRC; s++) applyStimulus(s, 2, 10);
    waitWords("t2_count", base, 40, 300);
    k = 0;
    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < NSRC; s++) begin
        for (int i = 0; i < ((r < 2) ? 4 : 2); i++) begin
          checkWord("t2_word", base + k, s, mkWord(s, 2, r * 4 + i));
          k++;
        end
      end
    end
    if (rxCycle.size() >= base + 40) begin
      for (int j = 1; j < 40; j++) begin
        if (j < 33) expGap = ((j % 4) == 0) ? 2 : 1;
        else        expGap = ((j % 2) == 0) ? 3 : 1;
        checkOutput("t2_gap", 64'(rxCycle[base + j] - rxCycle[base + j - 1]), 64'(expGap));
      end
    end

    // Backpressure: only two pops may be outstanding while the consumer stalls
    bus.out_ready = 1'b0;
    doReset();
    base = rxData.size();
    pop0 = popTotal;
    applyStimulus(0, 3, 6);
    tick(6);
    checkOutput("t3_stall_pops", 64'(popTotal - pop0), 64'd2);
    checkOutput("t3_stall_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("t3_stall_re", 64'(bus.src_re), 64'd0);
    checkOutput("t3_stall_head", {30'd0, bus.out_src, bus.out_data}, {32'd0, mkWord(0, 3, 0)});
    tick(3);
    checkOutput("t3_hold_head", {30'd0, bus.out_src, bus.out_data}, {32'd0, mkWord(0, 3, 0)});
    checkOutput("t3_hold_pops", 64'(popTotal - pop0), 64'd2);
    checkOutput("t3_hold_rx", 64'(rxData.size() - base), 64'd0);
    bus.out_ready = 1'b1;
    waitWords("t3_count", base, 6, 100);
    for (int i = 0; i < 6; i++) checkWord("t3_word", base + i, 0, mkWord(0, 3, i));
    tick(5);
    checkOutput("t3_nodup", 64'(rxData.size() - base), 64'd6);
    checkOutput("t3_pops", 64'(popTotal - pop0), 64'd6);

    // Source runs dry before its quantum; pointer moves to it so src3 beats src1
    doReset();
    base = rxData.size();
    applyStimulus(2, 4, 2);
    tick();
    applyStimulus(3, 4, 1);
    applyStimulus(1, 4, 1);
    waitWords("t4_count", base, 4, 100);
    checkWord("t4_w0", base + 0, 2, mkWord(2, 4, 0));
    checkWord("t4_w1", base + 1, 2, mkWord(2, 4, 1));
    checkWord("t4_w2", base + 2, 3, mkWord(3, 4, 0));
    checkWord("t4_w3", base + 3, 1, mkWord(1, 4, 0));
    if (rxCycle.size() >= base + 4) begin
      checkOutput("t4_gap_dry", 64'(rxCycle[base + 2] - rxCycle[base + 1]), 64'd3);
      checkOutput("t4_gap_next", 64'(rxCycle[base + 3] - rxCycle[base + 2]), 64'd3);
    end

    // Pointer at src3 after reset with only src1 and src3 holding data
    doReset();
    base = rxData.size();
    applyStimulus(1, 5, 1);
    applyStimulus(3, 5, 1);
    waitWords("t5_count", base, 2, 100);
    checkWord("t5_first", base + 0, 1, mkWord(1, 5, 0));
    checkWord("t5_second", base + 1, 3, mkWord(3, 5, 0));

    // Reset in the middle of a src1 burst with words queued and in flight
    doReset();
    applyStimulus(0, 6, 4);
    applyStimulus(1, 6, 8);
    tick(8);
    checkOutput("t6_pre_re", 64'(bus.src_re), 64'b0010);
    checkOutput("t6_pre_valid", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    tick();
    checkOutput("t6_rst_re", 64'(bus.src_re), 64'd0);
    checkOutput("t6_rst_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("t6_rst_src", 64'(bus.out_src), 64'd0);
    checkOutput("t6_rst_data", 64'(bus.out_data), 64'd0);
    rst = 1'b0;
    base = rxData.size();
    applyStimulus(1, 7, 1);
    applyStimulus(0, 7, 1);
    waitWords("t6_count", base, 2, 100);
    checkWord("t6_first", base + 0, 0, mkWord(0, 7, 0));
    checkWord("t6_second", base + 1, 1, mkWord(1, 7, 0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
